// File: rtl/cpu_bus_responder_if.sv
// CPU memory-bus bundle between a microcode sequencer (master) and an
// on-chip RAM region responder (slave). Signal names follow the CPU's
// own bus naming so the two sides line up with the address decoder.
interface cpu_bus_responder_if;
  logic        i_Address_Out;
  logic [15:0] i_Address;
  logic        i_Bus_In;
  logic        i_Bus_Out;
  logic [7:0]  i_Data;
  logic [7:0]  o_Data;
  logic        o_Data_Valid;
  logic        o_Ready;
  logic        o_Hit;
  logic        o_Error;

  modport master (
    output i_Address_Out, i_Address, i_Bus_In, i_Bus_Out, i_Data,
    input  o_Data, o_Data_Valid, o_Ready, o_Hit, o_Error
  );

  modport slave (
    input  i_Address_Out, i_Address, i_Bus_In, i_Bus_Out, i_Data,
    output o_Data, o_Data_Valid, o_Ready, o_Hit, o_Error
  );
endinterface

// File: rtl/cpu_bus_responder.sv
// Target side of the CPU memory bus for one RAM-backed region
// [BASE_ADDR, LAST_ADDR]. The address strobe latches the address and the
// hit flag; a read or write strobe then completes after WAIT_STATES extra
// clocks. The latched address is kept after each access so the CPU can
// issue back-to-back accesses to the same location without re-strobing.
// Optional feature macro: BUS_RESP_DEFAULT_RESPONDER_EN -- when defined,
// reads that miss the region return 8'hFF with a valid pulse (open bus);
// when undefined, missed reads complete silently.
module cpu_bus_responder #(
  parameter logic [15:0] BASE_ADDR   = 16'hFF80,
  parameter logic [15:0] LAST_ADDR   = 16'hFFFE,
  parameter int          WAIT_STATES = 0
) (
  input logic               i_Clk,
  input logic               i_Reset,
  cpu_bus_responder_if.slave bus
);

  localparam int DEPTH = int'(LAST_ADDR) - int'(BASE_ADDR) + 1;
  localparam int OFF_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_WAIT,
    S_RESPOND
  } state_t;

  state_t           state;
  logic [15:0]      addr_reg;
  logic [3:0]       wait_cnt;
  logic             read_reg;
  logic [7:0]       wdata_reg;
  logic [7:0]       mem [DEPTH];

  logic             strobe_one;
  logic             strobe_both;
  logic             start_access;
  logic             complete;
  logic             cur_read;
  logic [7:0]       cur_wdata;
  logic [OFF_W-1:0] offset;

  // A single read or write strobe is a legal request; both at once is a conflict
  assign strobe_one   = bus.i_Bus_In ^ bus.i_Bus_Out;
  assign strobe_both  = bus.i_Bus_In & bus.i_Bus_Out;
  assign start_access = (state == S_ARMED) && !bus.i_Address_Out && strobe_one;

  // Completion happens on the strobe edge itself with no wait states, otherwise when the counter expires
  assign complete  = (start_access && (WAIT_STATES == 0)) || ((state == S_WAIT) && (wait_cnt == 4'd0));
  assign cur_read  = (state == S_WAIT) ? read_reg  : bus.i_Bus_In;
  assign cur_wdata = (state == S_WAIT) ? wdata_reg : bus.i_Data;
  assign offset    = OFF_W'(addr_reg - BASE_ADDR);

  // Bus protocol FSM; every bus output is registered here
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      state            <= S_IDLE;
      addr_reg         <= 16'h0000;
      wait_cnt         <= 4'd0;
      read_reg         <= 1'b0;
      wdata_reg        <= 8'h00;
      bus.o_Data       <= 8'h00;
      bus.o_Data_Valid <= 1'b0;
      bus.o_Ready      <= 1'b1;
      bus.o_Hit        <= 1'b0;
      bus.o_Error      <= 1'b0;
    end else begin
      bus.o_Data_Valid <= 1'b0;
      bus.o_Error      <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.i_Address_Out) begin
            addr_reg  <= bus.i_Address;
            bus.o_Hit <= (bus.i_Address >= BASE_ADDR) && (bus.i_Address <= LAST_ADDR);
            state     <= S_ARMED;
          end else if (bus.i_Bus_In || bus.i_Bus_Out) begin
            bus.o_Error <= 1'b1;
          end
        end
        S_ARMED: begin
          if (bus.i_Address_Out) begin
            addr_reg  <= bus.i_Address;
            bus.o_Hit <= (bus.i_Address >= BASE_ADDR) && (bus.i_Address <= LAST_ADDR);
          end else if (strobe_both) begin
            bus.o_Error <= 1'b1;
          end else if (strobe_one) begin
            read_reg  <= bus.i_Bus_In;
            wdata_reg <= bus.i_Data;
            if (WAIT_STATES > 0) begin
              wait_cnt    <= WAIT_LOAD;
              bus.o_Ready <= 1'b0;
              state       <= S_WAIT;
            end else begin
              state <= S_RESPOND;
            end
          end
        end
        S_WAIT: begin
          if (wait_cnt == 4'd0) begin
            bus.o_Ready <= 1'b1;
            state       <= S_RESPOND;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        S_RESPOND: begin
          state <= S_ARMED;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase

      if (complete && cur_read) begin
        if (bus.o_Hit) begin
          bus.o_Data       <= mem[offset];
          bus.o_Data_Valid <= 1'b1;
        end else begin
`ifdef BUS_RESP_DEFAULT_RESPONDER_EN
          bus.o_Data       <= 8'hFF;
          bus.o_Data_Valid <= 1'b1;
`endif
        end
      end
    end
  end

  // Region RAM has no reset so its contents survive i_Reset; misses never write
  always_ff @(posedge i_Clk) begin
    if (complete && !cur_read && bus.o_Hit) begin
      mem[offset] <= cur_wdata;
    end
  end

endmodule

// File: tb/tb_cpu_bus_responder.sv
// Self-checking bench for cpu_bus_responder. Two instances share clock and
// reset: index 0 has no wait states, index 1 has one wait state. A
// behavioural model holds the region contents per instance, keyed by full
// CPU address, and predicts hit, latency, data and ready-low cycles.
// Optional feature macro: BUS_RESP_DEFAULT_RESPONDER_EN.
module tb_cpu_bus_responder;

  logic clk = 1'b0;
  logic rst = 1'b0;

  cpu_bus_responder_if bus0 ();
  cpu_bus_responder_if bus1 ();

  cpu_bus_responder #(.BASE_ADDR(16'hFF80), .LAST_ADDR(16'hFFFE), .WAIT_STATES(0)) dut0 (
    .i_Clk(clk), .i_Reset(rst), .bus(bus0));
  cpu_bus_responder #(.BASE_ADDR(16'hFF80), .LAST_ADDR(16'hFFFE), .WAIT_STATES(1)) dut1 (
    .i_Clk(clk), .i_Reset(rst), .bus(bus1));

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] ref_mem [2][65536];
  logic [7:0] last_data [2];

  typedef struct {
    int          sel;
    bit          rd;
    logic [15:0] addr;
    logic [7:0]  wd;
  } op_t;

  task automatic drive(input int sel, input logic ao, input logic [15:0] a,
                       input logic bi, input logic bo, input logic [7:0] dt);
    if (sel == 0) begin
      bus0.i_Address_Out = ao; bus0.i_Address = a; bus0.i_Bus_In = bi; bus0.i_Bus_Out = bo; bus0.i_Data = dt;
    end else begin
      bus1.i_Address_Out = ao; bus1.i_Address = a; bus1.i_Bus_In = bi; bus1.i_Bus_Out = bo; bus1.i_Data = dt;
    end
  endtask

  task automatic sample(input int sel, output logic [7:0] d, output logic v, output logic r,
                        output logic h, output logic e);
    if (sel == 0) begin
      d = bus0.o_Data; v = bus0.o_Data_Valid; r = bus0.o_Ready; h = bus0.o_Hit; e = bus0.o_Error;
    end else begin
      d = bus1.o_Data; v = bus1.o_Data_Valid; r = bus1.o_Ready; h = bus1.o_Hit; e = bus1.o_Error;
    end
  endtask

  // Reference model: instance sel has sel wait states; region FF80..FFFE, no wrap
  task automatic model_op(input int sel, input bit rd, input logic [15:0] addr, input logic [7:0] wd,
                          output logic exp_hit, output int exp_lat, output logic [7:0] exp_data,
                          output int exp_rlow);
    exp_hit = (addr >= 16'hFF80) && (addr <= 16'hFFFE);
    exp_lat = 0;
    if (rd) begin
      if (exp_hit) begin
        last_data[sel] = ref_mem[sel][addr];
        exp_lat = 1 + sel;
      end else begin
`ifdef BUS_RESP_DEFAULT_RESPONDER_EN
        last_data[sel] = 8'hFF;
        exp_lat = 1 + sel;
`endif
      end
    end else if (exp_hit) begin
      ref_mem[sel][addr] = wd;
    end
    exp_data = last_data[sel];
    exp_rlow = sel;
  endtask

  // One bus transaction: optional address strobe, one data-strobe cycle, then a fixed observation window
  task automatic do_access(input int sel, input bit new_addr, input logic rd, input logic wr,
                           input logic [15:0] addr, input logic [7:0] wd,
                           output logic obs_hit, output int lat, output logic [7:0] obs_data,
                           output bit err_seen, output int rlow);
    logic [7:0] d;
    logic v, r, h, e;
    lat = 0; err_seen = 0; rlow = 0; obs_data = 8'h00;
    if (new_addr) begin
      @(negedge clk);
      drive(sel, 1'b1, addr, 1'b0, 1'b0, 8'h00);
    end
    @(negedge clk);
    sample(sel, d, v, r, h, e);
    obs_hit = h;
    drive(sel, 1'b0, addr, rd, wr, wd);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) drive(sel, 1'b0, addr, 1'b0, 1'b0, 8'h00);
      sample(sel, d, v, r, h, e);
      if (e === 1'b1) err_seen = 1;
      if (r !== 1'b1) rlow++;
      if (v === 1'b1 && lat == 0) begin
        lat = k;
        obs_data = d;
      end
    end
    if (lat == 0) obs_data = d;
  endtask

  task automatic test_reset();
    logic [7:0] d;
    logic v, r, h, e;
    drive(0, 1'b0, 16'h0000, 1'b0, 1'b0, 8'h00);
    drive(1, 1'b0, 16'h0000, 1'b0, 1'b0, 8'h00);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sample(s, d, v, r, h, e);
      vectors += 5;
      if (d !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_data%0d: got %h want 00", s, d); end
      if (v !== 1'b0)  begin miscompares++; $display("[TB] FAIL reset_valid%0d: got %b want 0", s, v); end
      if (r !== 1'b1)  begin miscompares++; $display("[TB] FAIL reset_ready%0d: got %b want 1", s, r); end
      if (h !== 1'b0)  begin miscompares++; $display("[TB] FAIL reset_hit%0d: got %b want 0", s, h); end
      if (e !== 1'b0)  begin miscompares++; $display("[TB] FAIL reset_error%0d: got %b want 0", s, e); end
    end
    rst = 1'b0;
    last_data[0] = 8'h00;
    last_data[1] = 8'h00;
  endtask

  task automatic test_idle_strobe();
    logic h;
    logic [7:0] d;
    int lat, rlow;
    bit err;
    for (int s = 0; s < 2; s++) begin
      do_access(s, 1'b0, 1'b1, 1'b0, 16'hFF90, 8'h00, h, lat, d, err, rlow);
      vectors += 3;
      if (err !== 1'b1) begin miscompares++; $display("[TB] FAIL idle_err%0d: got %b want 1", s, err); end
      if (lat != 0)     begin miscompares++; $display("[TB] FAIL idle_valid%0d: got lat %0d want none", s, lat); end
      if (d !== 8'h00)  begin miscompares++; $display("[TB] FAIL idle_data%0d: got %h want 00", s, d); end
    end
  endtask

  task automatic test_directed();
    op_t tbl[17] = '{
      '{1, 1'b0, 16'hFF90, 8'hA5}, '{1, 1'b1, 16'hFF90, 8'h00},
      '{0, 1'b0, 16'hFF80, 8'h34}, '{0, 1'b0, 16'hFF81, 8'h12},
      '{0, 1'b1, 16'hFF80, 8'h00}, '{0, 1'b1, 16'hFF81, 8'h00},
      '{1, 1'b0, 16'hFF80, 8'h5C}, '{1, 1'b0, 16'hFFFF, 8'h01},
      '{1, 1'b1, 16'hFF80, 8'h00}, '{1, 1'b1, 16'hC000, 8'h00},
      '{0, 1'b1, 16'hC000, 8'h00}, '{1, 1'b0, 16'hFFFE, 8'hE7},
      '{1, 1'b1, 16'hFFFE, 8'h00}, '{1, 1'b0, 16'hFF7F, 8'h99},
      '{1, 1'b1, 16'hFF7F, 8'h00}, '{0, 1'b0, 16'hFFFF, 8'h01},
      '{0, 1'b1, 16'hFF80, 8'h00}
    };
    logic exp_hit, h;
    logic [7:0] exp_data, d;
    int exp_lat, exp_rlow, lat, rlow;
    bit err;
    foreach (tbl[i]) begin
      model_op(tbl[i].sel, tbl[i].rd, tbl[i].addr, tbl[i].wd, exp_hit, exp_lat, exp_data, exp_rlow);
      do_access(tbl[i].sel, 1'b1, tbl[i].rd, !tbl[i].rd, tbl[i].addr, tbl[i].wd, h, lat, d, err, rlow);
      vectors += 5;
      if (h !== exp_hit)    begin miscompares++; $display("[TB] FAIL dir%0d_hit: got %b want %b", i, h, exp_hit); end
      if (lat != exp_lat)   begin miscompares++; $display("[TB] FAIL dir%0d_latency: got %0d want %0d", i, lat, exp_lat); end
      if (d !== exp_data)   begin miscompares++; $display("[TB] FAIL dir%0d_data: got %h want %h", i, d, exp_data); end
      if (rlow != exp_rlow) begin miscompares++; $display("[TB] FAIL dir%0d_ready_low: got %0d want %0d", i, rlow, exp_rlow); end
      if (err !== 1'b0)     begin miscompares++; $display("[TB] FAIL dir%0d_error: got %b want 0", i, err); end
    end
  endtask

  task automatic test_conflict();
    logic exp_hit, h;
    logic [7:0] exp_data, d;
    int exp_lat, exp_rlow, lat, rlow;
    bit err;
    for (int s = 0; s < 2; s++) begin
      model_op(s, 1'b0, 16'hFF85, 8'h5A, exp_hit, exp_lat, exp_data, exp_rlow);
      do_access(s, 1'b1, 1'b0, 1'b1, 16'hFF85, 8'h5A, h, lat, d, err, rlow);
      do_access(s, 1'b1, 1'b1, 1'b1, 16'hFF85, 8'hC3, h, lat, d, err, rlow);
      vectors += 4;
      if (err !== 1'b1)   begin miscompares++; $display("[TB] FAIL conflict%0d_err: got %b want 1", s, err); end
      if (lat != 0)       begin miscompares++; $display("[TB] FAIL conflict%0d_valid: got lat %0d want none", s, lat); end
      if (d !== exp_data) begin miscompares++; $display("[TB] FAIL conflict%0d_data: got %h want %h", s, d, exp_data); end
      if (rlow != 0)      begin miscompares++; $display("[TB] FAIL conflict%0d_ready_low: got %0d want 0", s, rlow); end
      model_op(s, 1'b1, 16'hFF85, 8'h00, exp_hit, exp_lat, exp_data, exp_rlow);
      do_access(s, 1'b0, 1'b1, 1'b0, 16'hFF85, 8'h00, h, lat, d, err, rlow);
      vectors += 2;
      if (d !== exp_data) begin miscompares++; $display("[TB] FAIL conflict%0d_ram: got %h want %h", s, d, exp_data); end
      if (lat != exp_lat) begin miscompares++; $display("[TB] FAIL conflict%0d_after_lat: got %0d want %0d", s, lat, exp_lat); end
    end
  endtask

  task automatic test_back_to_back();
    logic exp_hit, h;
    logic [7:0] exp_data, d, val;
    int exp_lat, exp_rlow, lat, rlow;
    bit err, rd;
    for (int s = 0; s < 2; s++) begin
      for (int n = 0; n < 4; n++) begin
        rd  = n[0];
        val = 8'($urandom_range(0, 255));
        model_op(s, rd, 16'hFFC0, val, exp_hit, exp_lat, exp_data, exp_rlow);
        do_access(s, n == 0, rd, !rd, 16'hFFC0, val, h, lat, d, err, rlow);
        vectors += 2;
        if (lat != exp_lat) begin miscompares++; $display("[TB] FAIL b2b%0d_%0d_latency: got %0d want %0d", s, n, lat, exp_lat); end
        if (d !== exp_data) begin miscompares++; $display("[TB] FAIL b2b%0d_%0d_data: got %h want %h", s, n, d, exp_data); end
      end
    end
  endtask

  task automatic test_reset_abort();
    logic exp_hit, h;
    logic [7:0] exp_data, d;
    logic v, r, e;
    int exp_lat, exp_rlow, lat, rlow;
    bit err;
    model_op(1, 1'b0, 16'hFFA0, 8'h3C, exp_hit, exp_lat, exp_data, exp_rlow);
    do_access(1, 1'b1, 1'b0, 1'b1, 16'hFFA0, 8'h3C, h, lat, d, err, rlow);
    @(negedge clk);
    drive(1, 1'b1, 16'hFFA0, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    drive(1, 1'b0, 16'hFFA0, 1'b0, 1'b1, 8'h77);
    @(negedge clk);
    drive(1, 1'b0, 16'hFFA0, 1'b0, 1'b0, 8'h00);
    vectors++;
    if (bus1.o_Ready !== 1'b0) begin miscompares++; $display("[TB] FAIL abort_wait_ready: got %b want 0", bus1.o_Ready); end
    rst = 1'b1;
    @(negedge clk);
    sample(1, d, v, r, h, e);
    vectors += 5;
    if (d !== 8'h00) begin miscompares++; $display("[TB] FAIL abort_data: got %h want 00", d); end
    if (v !== 1'b0)  begin miscompares++; $display("[TB] FAIL abort_valid: got %b want 0", v); end
    if (r !== 1'b1)  begin miscompares++; $display("[TB] FAIL abort_ready: got %b want 1", r); end
    if (h !== 1'b0)  begin miscompares++; $display("[TB] FAIL abort_hit: got %b want 0", h); end
    if (e !== 1'b0)  begin miscompares++; $display("[TB] FAIL abort_error: got %b want 0", e); end
    rst = 1'b0;
    last_data[0] = 8'h00;
    last_data[1] = 8'h00;
    model_op(1, 1'b1, 16'hFFA0, 8'h00, exp_hit, exp_lat, exp_data, exp_rlow);
    do_access(1, 1'b1, 1'b1, 1'b0, 16'hFFA0, 8'h00, h, lat, d, err, rlow);
    vectors += 2;
    if (d !== exp_data) begin miscompares++; $display("[TB] FAIL abort_readback: got %h want %h", d, exp_data); end
    if (lat != exp_lat) begin miscompares++; $display("[TB] FAIL abort_latency: got %0d want %0d", lat, exp_lat); end
  endtask

  task automatic test_random();
    bit known [2][65536];
    logic exp_hit, h;
    logic [7:0] exp_data, d, wd;
    logic [15:0] addr;
    int exp_lat, exp_rlow, lat, rlow, s;
    bit err, rd;
    for (int i = 0; i < 60; i++) begin
      s = int'($urandom_range(0, 1));
      case ($urandom_range(0, 9))
        0: addr = 16'hC000;
        1: addr = 16'hFFFF;
        2: addr = 16'hFF7F;
        3: addr = 16'hFFFE;
        4: addr = 16'hFF80;
        default: addr = 16'hFF80 + 16'($urandom_range(0, 126));
      endcase
      rd = $urandom_range(0, 1) == 1;
      if (addr >= 16'hFF80 && addr <= 16'hFFFE && !known[s][addr]) rd = 1'b0;
      if (!rd) known[s][addr] = 1'b1;
      wd = 8'($urandom_range(0, 255));
      model_op(s, rd, addr, wd, exp_hit, exp_lat, exp_data, exp_rlow);
      do_access(s, 1'b1, rd, !rd, addr, wd, h, lat, d, err, rlow);
      vectors += 5;
      if (h !== exp_hit)    begin miscompares++; $display("[TB] FAIL rnd%0d_hit: addr %h got %b want %b", i, addr, h, exp_hit); end
      if (lat != exp_lat)   begin miscompares++; $display("[TB] FAIL rnd%0d_latency: addr %h got %0d want %0d", i, addr, lat, exp_lat); end
      if (d !== exp_data)   begin miscompares++; $display("[TB] FAIL rnd%0d_data: addr %h got %h want %h", i, addr, d, exp_data); end
      if (rlow != exp_rlow) begin miscompares++; $display("[TB] FAIL rnd%0d_ready_low: got %0d want %0d", i, rlow, exp_rlow); end
      if (err !== 1'b0)     begin miscompares++; $display("[TB] FAIL rnd%0d_error: got %b want 0", i, err); end
    end
  endtask

  initial begin
    test_reset();
    test_idle_strobe();
    test_directed();
    test_conflict();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] simulation timeout");
  end

endmodule
